// File: rtl/dmaw_pkg.sv
// Shared types and helpers for the DMA write-data packer.
package dmaw_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StFwd,
      StPack,
      StDrain
   } dmaw_state_e;

   localparam int unsigned DefAxiDw  = 128;
   localparam int unsigned DefInDw   = 32;
   // Widest beat supported by the strobe helper (1024-bit data).
   localparam int unsigned MaxStrbW  = 128;

   // Strobe mask covering nbytes bytes starting at word lane 'lane'.
   function automatic logic [MaxStrbW-1:0] strb_mask(input int unsigned lane,
                                                     input int unsigned nbytes,
                                                     input int unsigned in_bytes);
      logic [MaxStrbW-1:0] mask;
      int unsigned         lo;
      mask = '0;
      lo   = lane * in_bytes;
      for (int unsigned b = 0; b < MaxStrbW; b++) begin
         mask[b] = (b >= lo) && (b < lo + nbytes);
      end
      return mask;
   endfunction

endpackage

// File: rtl/dmaw_out_reg.sv
// Single-entry valid/ready holding register for packed beats.
module dmaw_out_reg #(
   parameter int unsigned DW = 128,
   parameter int unsigned SW = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [DW-1:0] push_data_i,
   input  logic [SW-1:0] push_strb_i,
   input  logic          push_last_i,
   output logic          push_ready_o,
   output logic          valid_o,
   output logic [DW-1:0] data_o,
   output logic [SW-1:0] strb_o,
   output logic          last_o,
   input  logic          ready_i
);

   logic          valid_q;
   logic [DW-1:0] data_q;
   logic [SW-1:0] strb_q;
   logic          last_q;

   // A new beat may enter when empty or when the held beat leaves this cycle.
   assign push_ready_o = !valid_q || ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         strb_q  <= '0;
         last_q  <= 1'b0;
      end else if (push_i) begin
         valid_q <= 1'b1;
         data_q  <= push_data_i;
         strb_q  <= push_strb_i;
         last_q  <= push_last_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign strb_o  = strb_q;
   assign last_o  = last_q;

endmodule

// File: rtl/dmaw_packer.sv
// Packs a narrow write-data stream into address-aligned AXI beats with strobes and last.
// Optional DMAW_PACKER_ALIGN_CHECK_EN flags sub-word start addresses on cmd_err.
module dmaw_packer
   import dmaw_pkg::*;
#(
   parameter int unsigned AXI_DW = DefAxiDw,
   parameter int unsigned IN_DW  = DefInDw
) (
   input  logic                  usr_clk,
   input  logic                  usr_reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [31:0]           cmd_sa,
   input  logic [31:0]           cmd_len,
   input  logic [IN_DW-1:0]      in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  cfg_dmaw_valid,
   input  logic                  cfg_dmaw_ready,
   output logic [31:0]           cfg_dmaw_sa,
   output logic [31:0]           cfg_dmaw_len,
   output logic [AXI_DW-1:0]     dmaw_data,
   output logic [AXI_DW/8-1:0]   dmaw_strb,
   output logic                  dmaw_last,
   output logic                  dmaw_valid,
   input  logic                  dmaw_ready,
   output logic                  cmd_err
);

   localparam int unsigned AXI_BYTES = AXI_DW / 8;
   localparam int unsigned IN_BYTES  = IN_DW / 8;
   localparam int unsigned RATIO     = AXI_DW / IN_DW;
   localparam int unsigned InShift   = $clog2(IN_BYTES);
   localparam int unsigned LaneW     = (RATIO > 1) ? $clog2(RATIO) : 1;

   dmaw_state_e          state_q;
   logic                 cmd_ready_q;
   logic                 cfg_valid_q;
   logic [31:0]          sa_q;
   logic [31:0]          len_q;
   logic [31:0]          rem_q;
   logic [LaneW-1:0]     lane_q;
   logic [AXI_DW-1:0]    asm_data_q;
   logic [AXI_BYTES-1:0] asm_strb_q;

   logic [31:0]          sa_aligned;
   logic [LaneW-1:0]     lane_init;
   logic [31:0]          take;
   logic [31:0]          rem_next;
   logic [LaneW-1:0]     lane_next;
   logic                 lane_wrap;
   logic                 word_completes;
   logic                 word_acc;
   logic                 push_ready;
   logic [AXI_BYTES-1:0] word_strb;
   logic [AXI_DW-1:0]    word_bmask;
   logic [AXI_DW-1:0]    word_shift;
   logic [AXI_DW-1:0]    beat_data;
   logic [AXI_BYTES-1:0] beat_strb;

   assign sa_aligned = cmd_sa & ~32'(IN_BYTES - 1);
   assign lane_init  = LaneW'((cmd_sa >> InShift) & 32'(RATIO - 1));

   always_comb begin
      take           = (rem_q < 32'(IN_BYTES)) ? rem_q : 32'(IN_BYTES);
      rem_next       = rem_q - take;
      lane_wrap      = (lane_q == LaneW'(RATIO - 1));
      lane_next      = lane_wrap ? '0 : lane_q + LaneW'(1);
      word_completes = lane_wrap || (rem_next == 32'd0);
      word_strb      = AXI_BYTES'(strb_mask(int'(lane_q), take, IN_BYTES));
      word_bmask     = '0;
      for (int unsigned i = 0; i < AXI_DW; i++) begin
         word_bmask[i] = word_strb[i / 8];
      end
      word_shift     = AXI_DW'(in_data) << (int'(lane_q) * IN_DW);
      // Bytes past the command length are zeroed, not just unstrobed.
      beat_data      = asm_data_q | (word_shift & word_bmask);
      beat_strb      = asm_strb_q | word_strb;
   end

   // A completing word needs room in the output register; other words never stall.
   assign in_ready = (state_q == StPack) && (!word_completes || push_ready);
   assign word_acc = in_valid && in_ready;

   always_ff @(posedge usr_clk) begin
      if (usr_reset) begin
         state_q     <= StIdle;
         cmd_ready_q <= 1'b1;
         cfg_valid_q <= 1'b0;
         sa_q        <= '0;
         len_q       <= '0;
         rem_q       <= '0;
         lane_q      <= '0;
         asm_data_q  <= '0;
         asm_strb_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  sa_q        <= sa_aligned;
                  len_q       <= cmd_len;
                  rem_q       <= cmd_len;
                  lane_q      <= lane_init;
                  asm_data_q  <= '0;
                  asm_strb_q  <= '0;
                  cmd_ready_q <= 1'b0;
                  cfg_valid_q <= 1'b1;
                  state_q     <= StFwd;
               end
            end
            StFwd: begin
               if (cfg_dmaw_ready) begin
                  cfg_valid_q <= 1'b0;
                  if (len_q == 32'd0) begin
                     cmd_ready_q <= 1'b1;
                     state_q     <= StIdle;
                  end else begin
                     state_q <= StPack;
                  end
               end
            end
            StPack: begin
               if (word_acc) begin
                  rem_q  <= rem_next;
                  lane_q <= lane_next;
                  if (word_completes) begin
                     asm_data_q <= '0;
                     asm_strb_q <= '0;
                     if (rem_next == 32'd0) begin
                        state_q <= StDrain;
                     end
                  end else begin
                     asm_data_q <= beat_data;
                     asm_strb_q <= beat_strb;
                  end
               end
            end
            StDrain: begin
               if (dmaw_valid && dmaw_ready) begin
                  cmd_ready_q <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   dmaw_out_reg #(
      .DW (AXI_DW),
      .SW (AXI_BYTES)
   ) u_out_reg (
      .clk_i        (usr_clk),
      .rst_i        (usr_reset),
      .push_i       (word_acc && word_completes),
      .push_data_i  (beat_data),
      .push_strb_i  (beat_strb),
      .push_last_i  (rem_next == 32'd0),
      .push_ready_o (push_ready),
      .valid_o      (dmaw_valid),
      .data_o       (dmaw_data),
      .strb_o       (dmaw_strb),
      .last_o       (dmaw_last),
      .ready_i      (dmaw_ready)
   );

   assign cmd_ready      = cmd_ready_q;
   assign cfg_dmaw_valid = cfg_valid_q;
   assign cfg_dmaw_sa    = sa_q;
   assign cfg_dmaw_len   = len_q;

`ifdef DMAW_PACKER_ALIGN_CHECK_EN
   logic err_q;

   always_ff @(posedge usr_clk) begin
      if (usr_reset) begin
         err_q <= 1'b0;
      end else if ((state_q == StIdle) && cmd_valid &&
                   ((cmd_sa & 32'(IN_BYTES - 1)) != 32'd0)) begin
         err_q <= 1'b1;
      end
   end

   assign cmd_err = err_q;
`else
   assign cmd_err = 1'b0;
`endif

endmodule

// File: doc/dmaw_packer.md
Name: dmaw_packer

Overview:
- User-side write-data upsizer that sits directly upstream of the AXI master write path.
- Accepts a DMA write command (start address, byte length) and a narrow word stream of IN_DW bits.
- Packs the words into AXI_DW beats aligned to the start address, with correct byte strobes on the first and last partial beats and a last flag on the final beat.
- Drives the dmaw_data/dmaw_strb/dmaw_last/dmaw_valid/dmaw_ready interface and forwards the command on cfg_dmaw_*.

Parameters:
- AXI_DW, 128, output beat width in bits; power of two, ≥ IN_DW.
- IN_DW, 32, input word width in bits; power of two, ≥ 8.
- AXI_BYTES, AXI_DW/8, derived; bytes per output beat.
- IN_BYTES, IN_DW/8, derived; bytes per input word.
- RATIO, AXI_DW/IN_DW, derived; input words per output beat.

Ports:
- usr_clk  in  1  clock
- usr_reset  in  1  synchronous reset, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_sa  in  32  start byte address; must be IN_BYTES-aligned
- cmd_len  in  32  length in bytes
- in_data  in  IN_DW  input word; byte 0 is bits [7:0]
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted
- cfg_dmaw_valid  out  1  forwarded command valid
- cfg_dmaw_ready  in  1  downstream command accept
- cfg_dmaw_sa  out  32  forwarded start address
- cfg_dmaw_len  out  32  forwarded length
- dmaw_data  out  AXI_DW  packed beat
- dmaw_strb  out  AXI_BYTES  byte strobes
- dmaw_last  out  1  final beat of the command
- dmaw_valid  out  1  beat valid
- dmaw_ready  in  1  beat accept
- cmd_err  out  1  sticky misalignment flag (see Optional Feature)

Behaviour:
- Reset state: all outputs 0 except cmd_ready=1; FSM in IDLE; counters 0. Reset mid-command abandons the command silently; the partial beat is discarded.

FSM states:
- IDLE: cmd_ready=1. On cmd_valid:
  - Capture sa/len.
  - Lane pointer = sa[log2(AXI_BYTES)-1 : log2(IN_BYTES)].
  - Remaining bytes = len.
  - Go to FWD.
  - len==0: go to FWD, then return to IDLE with no data beats.
- FWD: cfg_dmaw_valid=1 with the captured sa/len. On cfg_dmaw_ready, go to PACK (or IDLE if len==0). Exactly one forwarded command per accepted cmd.
- PACK: in_ready=1 unless the assembly register is complete and the output register is full and not draining. Each accepted word:
  - Written to word lane = lane pointer.
  - Strobe bits set for min(IN_BYTES, remaining) low bytes of that lane.
  - Remaining decremented by the same amount; lane pointer incremented mod RATIO.
- Beat completion: lane pointer wraps to 0, or remaining reaches 0.
  - The assembly register moves to the output register in the same cycle if the output register is empty or being accepted that cycle.
  - dmaw_last=1 when remaining reached 0.
  - After the last beat moves, go to DRAIN.
- DRAIN: wait until the output register is accepted, then go to IDLE. cmd_ready rises the cycle after the last beat is accepted.

Data and timing rules:
- Unwritten lanes: data 0, strobe 0.
- Latency: first beat valid 1 cycle after its completing input word.
- Throughput: one input word per cycle sustained while dmaw_ready=1.
- The output register holds data/strb/last stable while dmaw_valid && !dmaw_ready.
- Simultaneous completion and drain in the same cycle: both occur, with no bubble.
- Remaining-byte arithmetic is 32-bit unsigned; no wrap is permitted (len ≤ 2^32-1).
- Input words beyond len are never requested: in_ready=0 outside PACK.

Optional Feature:
- Macro: DMAW_PACKER_ALIGN_CHECK_EN.
- With it defined:
  - Command capture checks cmd_sa[log2(IN_BYTES)-1:0]≠0.
  - If set: cmd_err is set sticky until usr_reset, and sa is forced down to IN_BYTES alignment (len unchanged, forwarded sa aligned).
- Without it: cmd_err is tied 0, and low address bits are ignored (treated as 0).

Decomposition:
- Package dmaw_pkg:
  - The FSM state enum (IDLE, FWD, PACK, DRAIN).
  - Default widths AXI_DW/IN_DW.
  - A function computing the strobe mask from a lane and a byte count.
- One sub-module, dmaw_out_reg: a single-entry valid/ready output register for data/strb/last.

Test Plan:
- Aligned beats: sa=0x1000, len=32, IN_DW=32, AXI_DW=128, 8 words, dmaw_ready=1.
  - Expect 2 beats, strb=0xFFFF both, last on beat 2.
  - Expect cfg_dmaw_sa=0x1000, cfg_dmaw_len=32.
- Misaligned start: sa=0x1008, len=12, 3 words.
  - Beat1: strb=0xFF00, words 0-1 in lanes 2-3.
  - Beat2: strb=0x000F, last=1.
- Partial tail: sa=0x0, len=6.
  - Single beat, strb=0x003F, data lane1 bytes 2-3 = 0, last=1.
  - in_ready drops after 2 words.
- Backpressure: len=64, dmaw_ready toggled 1/0 each cycle.
  - Data stable while stalled; 4 beats in order, no lost or duplicated words.
- Zero length and reset: len=0 → one cfg_dmaw handshake, no dmaw_valid, cmd_ready back high.
  - usr_reset mid-PACK: all outputs return to reset values next cycle.
  - A following command completes correctly.
- With DMAW_PACKER_ALIGN_CHECK_EN: sa=0x1002 → cmd_err=1, cfg_dmaw_sa=0x1000.
  - cmd_err stays 1 across later commands until reset.
